// File: rtl/fifo_rr_arbiter.sv
// Round-robin arbiter that drains four upstream FIFOs into one downstream FIFO.
// Each word takes POP (read strobe) then CAPT (sample data); push follows CAPT.
module fifo_rr_arbiter #(
    parameter int DATA_SIZE = 4,
    parameter int N_REQ     = 4
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [N_REQ-1:0]     fifo_empty_in,
    input  logic [DATA_SIZE-1:0] data_in0,
    input  logic [DATA_SIZE-1:0] data_in1,
    input  logic [DATA_SIZE-1:0] data_in2,
    input  logic [DATA_SIZE-1:0] data_in3,
    input  logic                 pause_in,
    output logic [N_REQ-1:0]     pop_out,
    output logic                 push_out,
    output logic [DATA_SIZE-1:0] data_out,
    output logic [1:0]           grant_id,
    output logic [7:0]           sent_count,
    output logic                 arb_idle
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        POP  = 2'd1,
        CAPT = 2'd2
    } state_t;

    state_t                 state_reg;
    logic [1:0]             rr_ptr_reg;
    logic [1:0]             winner_reg;

    logic [1:0]             cand_idx [N_REQ];
    logic [N_REQ-1:0]       cand_ok;
    logic                   win_valid;
    logic [1:0]             win_idx;
    logic                   arbitrate;
    logic [DATA_SIZE-1:0]   data_sel;

    // Candidate gi is the requester gi places after the round-robin pointer.
    generate
        for (genvar gi = 0; gi < N_REQ; gi++) begin : g_cand
            assign cand_idx[gi] = rr_ptr_reg + 2'(gi);
            assign cand_ok[gi]  = ~fifo_empty_in[cand_idx[gi]];
        end
    endgenerate

    // Walk from the farthest candidate back so the nearest eligible one wins.
    always_comb begin
        win_valid = 1'b0;
        win_idx   = rr_ptr_reg;
        for (int k = N_REQ - 1; k >= 0; k--) begin
            if (cand_ok[k]) begin
                win_valid = 1'b1;
                win_idx   = cand_idx[k];
            end
        end
    end

    assign arbitrate = (state_reg != POP) && !pause_in && win_valid;

    always_comb begin
        case (winner_reg)
            2'd0:    data_sel = data_in0;
            2'd1:    data_sel = data_in1;
            2'd2:    data_sel = data_in2;
            default: data_sel = data_in3;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg  <= IDLE;
            rr_ptr_reg <= 2'd0;
            winner_reg <= 2'd0;
            pop_out    <= '0;
            push_out   <= 1'b0;
            data_out   <= '0;
            grant_id   <= 2'd0;
            sent_count <= 8'd0;
        end else begin
            pop_out  <= '0;
            push_out <= 1'b0;
            case (state_reg)
                IDLE, CAPT: begin
                    if (state_reg == CAPT) begin
                        data_out   <= data_sel;
                        grant_id   <= winner_reg;
                        push_out   <= 1'b1;
                        sent_count <= sent_count + 8'd1;
                    end
                    if (arbitrate) begin
                        state_reg  <= POP;
                        pop_out    <= {{(N_REQ-1){1'b0}}, 1'b1} << win_idx;
                        winner_reg <= win_idx;
                        rr_ptr_reg <= win_idx + 2'd1;
                    end else begin
                        state_reg <= IDLE;
                    end
                end
                POP:     state_reg <= CAPT;
                default: state_reg <= IDLE;
            endcase
        end
    end

    assign arb_idle = (state_reg == IDLE);

endmodule

// File: tb/tb_fifo_rr_arbiter.sv
// Bench: upstream FIFOs as queues, a cycle-level transaction model of the
// arbiter, a per-cycle compare process, plus directed literal scenarios.
module tb_fifo_rr_arbiter;
    localparam int DW = 4;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic [3:0]    empty_r = 4'hF;
    logic [DW-1:0] data_r [4];
    logic          pause = 1'b0;
    logic [3:0]    pop_out;
    logic          push_out;
    logic [DW-1:0] data_out;
    logic [1:0]    grant_id;
    logic [7:0]    sent_count;
    logic          arb_idle;

    logic [DW-1:0] q [4][$];
    logic [3:0]    pop_seen = 4'h0;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    fifo_rr_arbiter #(.DATA_SIZE(DW), .N_REQ(4)) dut (
        .clk(clk), .reset(reset), .fifo_empty_in(empty_r),
        .data_in0(data_r[0]), .data_in1(data_r[1]),
        .data_in2(data_r[2]), .data_in3(data_r[3]),
        .pause_in(pause), .pop_out(pop_out), .push_out(push_out),
        .data_out(data_out), .grant_id(grant_id),
        .sent_count(sent_count), .arb_idle(arb_idle)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            if (n_bad <= 30)
                $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic update_flags();
        for (int i = 0; i < 4; i++) empty_r[i] = (q[i].size() == 0);
    endtask

    // Upstream FIFOs: a strobe seen in cycle T presents the word in T+1.
    always @(negedge clk) pop_seen = pop_out;
    initial for (int i = 0; i < 4; i++) data_r[i] = '0;
    always @(posedge clk) begin
        #1;
        for (int i = 0; i < 4; i++)
            if (pop_seen[i] && q[i].size() > 0) data_r[i] = q[i].pop_front();
        update_flags();
    end

    // Transaction model: a grant may be issued unless a pop is outstanding this
    // cycle; the granted word is pushed two cycles after its strobe.
    logic [3:0]    m_pop = 0;
    logic          m_push = 0;
    logic [DW-1:0] m_data = 0;
    logic [1:0]    m_gid = 0;
    logic [7:0]    m_cnt = 0;
    logic          m_idle = 1;
    logic          m_valid = 0;
    int            m_ptr = 0;
    int            m_win = 0;
    logic          m_capt = 0;

    always @(posedge clk) begin
        logic was_pop;
        logic granted;
        int   w;
        if (reset) begin
            m_pop = 0; m_push = 0; m_data = 0; m_gid = 0; m_cnt = 0;
            m_ptr = 0; m_idle = 1; m_capt = 0; m_valid = 1;
        end else begin
            was_pop = (m_pop != 0);
            m_push = 0;
            if (m_capt) begin
                m_push = 1;
                m_data = data_r[m_win];
                m_gid  = 2'(m_win);
                m_cnt  = m_cnt + 8'd1;
            end
            granted = 0;
            w = 0;
            if (!was_pop && !pause)
                for (int k = 0; k < 4; k++)
                    if (!granted && !empty_r[(m_ptr + k) % 4]) begin
                        granted = 1;
                        w = (m_ptr + k) % 4;
                    end
            m_capt = was_pop;
            m_pop  = granted ? 4'(1 << w) : 4'h0;
            if (granted) begin
                m_win = w;
                m_ptr = (w + 1) % 4;
            end
            m_idle = !granted && !was_pop;
        end
    end

    always @(negedge clk) begin
        if (m_valid) begin
            chk("pop_out", 32'(pop_out), 32'(m_pop));
            chk("push_out", 32'(push_out), 32'(m_push));
            chk("data_out", 32'(data_out), 32'(m_data));
            chk("grant_id", 32'(grant_id), 32'(m_gid));
            chk("sent_count", 32'(sent_count), 32'(m_cnt));
            chk("arb_idle", 32'(arb_idle), 32'(m_idle));
        end
    end

    // Enter reset with pause low and empty FIFOs; returns at negedge+1 with reset held.
    task automatic enter_reset();
        reset = 1'b1;
        pause = 1'b0;
        for (int i = 0; i < 4; i++) q[i].delete();
        update_flags();
        @(negedge clk); #1;
    endtask

    task automatic fill(input int i, input int n);
        for (int k = 0; k < n; k++) q[i].push_back(DW'($urandom));
        update_flags();
    endtask

    initial begin
        int pushes;
        logic [3:0] exp_pop;

        #1;
        // Scenario: all four non-empty -> strict rotation every 2 cycles.
        enter_reset();
        for (int i = 0; i < 4; i++) fill(i, 8);
        reset = 1'b0;
        for (int j = 1; j <= 12; j++) begin
            @(negedge clk);
            exp_pop = (j % 2 == 1) ? 4'(1 << (((j - 1) / 2) % 4)) : 4'h0;
            chk("rot_pop", 32'(pop_out), 32'(exp_pop));
            if (j >= 3 && j % 2 == 1) begin
                chk("rot_push", 32'(push_out), 32'd1);
                chk("rot_gid", 32'(grant_id), 32'(((j - 3) / 2) % 4));
            end
        end
        #1;

        // Scenario: only FIFO 2 with 0xA, 0x5.
        enter_reset();
        q[2].push_back(4'hA); q[2].push_back(4'h5); update_flags();
        reset = 1'b0;
        for (int j = 1; j <= 6; j++) begin
            @(negedge clk);
            if (j == 1 || j == 3) chk("single_pop", 32'(pop_out), 32'h4);
            if (j == 3) chk("single_d0", 32'(data_out), 32'hA);
            if (j == 5) chk("single_d1", 32'(data_out), 32'h5);
            if (j == 6) begin
                chk("single_idle", 32'(arb_idle), 32'd1);
                chk("single_cnt", 32'(sent_count), 32'd2);
            end
        end
        #1;

        // Scenario: pause rises during POP.
        enter_reset();
        fill(1, 6);
        reset = 1'b0;
        @(negedge clk);
        chk("pause_first_pop", 32'(pop_out), 32'h2);
        #1 pause = 1'b1;
        for (int j = 2; j <= 6; j++) begin
            @(negedge clk);
            if (j >= 3) chk("pause_no_pop", 32'(pop_out), 32'h0);
            if (j == 3) chk("pause_push", 32'(push_out), 32'd1);
        end
        #1 pause = 1'b0;
        @(negedge clk);
        chk("pause_resume", 32'(pop_out), 32'h2);
        #1;

        // Scenario: reset during CAPT discards the word; pointer restarts at 0.
        enter_reset();
        fill(1, 4); fill(3, 4);
        reset = 1'b0;
        @(negedge clk);
        chk("rst_pop1", 32'(pop_out), 32'h2);
        @(negedge clk); #1 reset = 1'b1;
        @(negedge clk);
        chk("rst_push", 32'(push_out), 32'd0);
        chk("rst_data", 32'(data_out), 32'd0);
        chk("rst_cnt", 32'(sent_count), 32'd0);
        chk("rst_idle", 32'(arb_idle), 32'd1);
        #1 reset = 1'b0;
        @(negedge clk);
        chk("rst_regrant", 32'(pop_out), 32'h2);
        #1;

        // Scenario: all empty for 10 cycles.
        enter_reset();
        reset = 1'b0;
        for (int j = 0; j < 10; j++) begin
            @(negedge clk);
            chk("empty_pop", 32'(pop_out), 32'h0);
            chk("empty_push", 32'(push_out), 32'd0);
            chk("empty_idle", 32'(arb_idle), 32'd1);
        end
        #1;

        // Scenario: 256 words -> sent_count wraps, last word from requester 3.
        enter_reset();
        for (int i = 0; i < 4; i++) fill(i, 70);
        reset = 1'b0;
        pushes = 0;
        for (int j = 0; j < 700 && pushes < 256; j++) begin
            @(negedge clk);
            if (push_out) pushes++;
        end
        chk("wrap_reached", 32'(pushes), 32'd256);
        chk("wrap_cnt", 32'(sent_count), 32'd0);
        chk("wrap_gid", 32'(grant_id), 32'd3);
        #1;

        // Randomized traffic with pauses, refills and occasional resets.
        enter_reset();
        reset = 1'b0;
        for (int c = 0; c < 2000; c++) begin
            @(negedge clk); #1;
            pause = ($urandom_range(0, 9) < 2);
            reset = ($urandom_range(0, 199) == 0);
            for (int i = 0; i < 4; i++)
                if ($urandom_range(0, 5) == 0 && q[i].size() < 4)
                    q[i].push_back(DW'($urandom));
            update_flags();
        end
        reset = 1'b0;
        pause = 1'b0;
        repeat (8) @(negedge clk);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
